// File: rtl/mul16_seq.sv
// mul16_seq: sequential 16x16 unsigned shift-and-add multiplier.
//   One CLA16 adds the (multiplicand or zero) partial product into the upper
//   half of the accumulator each cycle; sixteen steps yield the 32-bit product.
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   start    request, sampled only while busy=0
//   a, b     16-bit multiplicand / multiplier, captured on an accepted start
//   busy     operation in progress
//   done     one-cycle pulse when product is valid
//   product  32-bit result, held until the next operation completes
//
// CLA16: 16-bit two-level carry-lookahead adder (4-bit groups).
//   A, B   addends;  Ci carry in;  S sum;  Co carry out

module CLA16 (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Ci,
  output logic [15:0] S,
  output logic        Co
);
  logic [15:0] p, g;
  logic [3:0]  gg, gp;   // group generate / propagate
  logic [4:0]  gc;       // carry into each group, gc[4] is the carry out

  assign p = A ^ B;
  assign g = A & B;

  for (genvar k = 0; k < 4; k++) begin : g_grp
    logic [3:0] pk, gk;
    logic       c1, c2, c3;
    assign pk = p[4*k +: 4];
    assign gk = g[4*k +: 4];
    assign c1 = gk[0] | (pk[0] & gc[k]);
    assign c2 = gk[1] | (pk[1] & gk[0]) | (pk[1] & pk[0] & gc[k]);
    assign c3 = gk[2] | (pk[2] & gk[1]) | (pk[2] & pk[1] & gk[0])
              | (pk[2] & pk[1] & pk[0] & gc[k]);
    assign gg[k] = gk[3] | (pk[3] & gk[2]) | (pk[3] & pk[2] & gk[1])
                 | (pk[3] & pk[2] & pk[1] & gk[0]);
    assign gp[k] = &pk;
    assign S[4*k +: 4] = pk ^ {c3, c2, c1, gc[k]};
  end

  // Second-level lookahead across the four groups.
  always_comb begin
    gc[0] = Ci;
    gc[1] = gg[0] | (gp[0] & Ci);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & Ci);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & Ci);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & Ci);
  end

  assign Co = gc[4];
endmodule

module mul16_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] mcand_q, mcand_d;
  // {upper sum, lower multiplier bits}. The carry bit above the upper half is
  // always zero after the shift (the adder carry lands in bit 31), so it is
  // not stored.
  logic [31:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] product_q, product_d;

  logic [15:0] add_b, sum;
  logic        co;

  assign add_b = acc_q[0] ? mcand_q : 16'h0000;

  CLA16 u_cla (
    .A  (acc_q[31:16]),
    .B  (add_b),
    .Ci (1'b0),
    .S  (sum),
    .Co (co)
  );

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          mcand_d = a;
          acc_d   = {16'h0000, b};
          cnt_d   = 5'd0;
        end
      end
      RUN: begin
        // Right shift of {carry, sum, lower}: nothing is lost.
        acc_d = {co, sum, acc_q[15:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd15) begin
          state_d   = DONE;
          product_d = acc_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= 16'h0000;
      acc_q     <= 32'h0;
      cnt_q     <= 5'd0;
      product_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // Both decoded straight from the state register, so they are glitch-free
  // and mutually exclusive.
  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;
endmodule
